// File: rtl/hazard_detection_if.sv
// Signal bundle between the ID-stage pipeline control and the hazard detection unit.
// The pipeline side uses the master modport and the hazard unit uses the slave modport.
interface hazard_detection_if #(
  parameter int REG_ADDR_SIZE = 5
);
  logic                     i_enable;
  logic [REG_ADDR_SIZE-1:0] i_id_rs;
  logic [REG_ADDR_SIZE-1:0] i_id_rt;
  logic                     i_id_uses_rt;
  logic                     i_ex_mem_read;
  logic [REG_ADDR_SIZE-1:0] i_ex_rt;
  logic                     i_id_jump_taken;
  logic                     i_id_halt;
  logic                     o_pc_write;
  logic                     o_if_id_write;
  logic                     o_if_id_flush;
  logic                     o_id_ex_bubble;
  logic                     o_halted;
  logic [15:0]              o_stall_count;

  modport master (
    output i_enable, i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_id_jump_taken, i_id_halt,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted,
           o_stall_count
  );

  modport slave (
    input  i_enable, i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_id_jump_taken, i_id_halt,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_halted,
           o_stall_count
  );
endinterface

// File: rtl/hazard_detection.sv
// Hazard detection beside the ID stage: load-use stall, taken-jump flush of IF/ID,
// and HALT handling that stops fetch, drains EX/MEM/WB and then reports halted.
module hazard_detection #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int DRAIN_CYCLES  = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  hazard_detection_if.slave hd
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_next_s;
  logic        halted_r;
  logic        halted_next_s;
  logic [15:0] stall_count_r;
  logic [15:0] stall_count_next_s;
  logic        hazard_s;
  logic        pc_write_s;
  logic        if_id_write_s;
  logic        if_id_flush_s;
  logic        id_ex_bubble_s;

  // Load-use detection; a load into $0 never creates a dependency.
  always_comb begin
    hazard_s = hd.i_ex_mem_read
             & (hd.i_ex_rt != {REG_ADDR_SIZE{1'b0}})
             & ((hd.i_ex_rt == hd.i_id_rs)
                | (hd.i_id_uses_rt & (hd.i_ex_rt == hd.i_id_rt)));
  end

  // Next-state and pipeline-control decode; reset or a frozen step drives every control low.
  always_comb begin
    state_next_s       = state_r;
    cnt_next_s         = cnt_r;
    halted_next_s      = halted_r;
    stall_count_next_s = stall_count_r;
    pc_write_s         = 1'b0;
    if_id_write_s      = 1'b0;
    if_id_flush_s      = 1'b0;
    id_ex_bubble_s     = 1'b0;
    if (!i_reset) begin
      state_next_s = ST_RUN;
    end else if (!hd.i_enable) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hazard_s) begin
            id_ex_bubble_s = 1'b1;
            if (stall_count_r != 16'hFFFF) begin
              stall_count_next_s = stall_count_r + 16'd1;
            end else begin
              stall_count_next_s = stall_count_r;
            end
          end else if (hd.i_id_halt) begin
            // HALT itself travels on as a NOP while fetch stops.
            state_next_s = ST_DRAIN;
            cnt_next_s   = DRAIN_INIT;
          end else begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
            if_id_flush_s = hd.i_id_jump_taken;
          end
        end
        ST_DRAIN: begin
          id_ex_bubble_s = 1'b1;
          if (cnt_r == 4'd0) begin
            state_next_s  = ST_HALTED;
            halted_next_s = 1'b1;
          end else begin
            cnt_next_s = cnt_r - 4'd1;
          end
        end
        ST_HALTED: begin
          id_ex_bubble_s = 1'b1;
        end
        default: begin
          state_next_s = ST_RUN;
          cnt_next_s   = 4'd0;
        end
      endcase
    end
  end

  // State, drain counter, halted flag and stall counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= ST_RUN;
      cnt_r         <= 4'd0;
      halted_r      <= 1'b0;
      stall_count_r <= 16'd0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      halted_r      <= halted_next_s;
      stall_count_r <= stall_count_next_s;
    end
  end

  assign hd.o_pc_write     = pc_write_s;
  assign hd.o_if_id_write  = if_id_write_s;
  assign hd.o_if_id_flush  = if_id_flush_s;
  assign hd.o_id_ex_bubble = id_ex_bubble_s;
  assign hd.o_halted       = halted_r;
  assign hd.o_stall_count  = stall_count_r;

endmodule

// File: tb/tb_hazard_detection.sv
// Scoreboard bench for hazard_detection: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares against the DUT.
module tb_hazard_detection;

  localparam int DRAIN = 4;

  typedef struct {
    bit          pc_write;
    bit          if_id_write;
    bit          flush;
    bit          bubble;
    bit          halted;
    logic [15:0] stalls;
  } exp_t;

  logic i_clk;
  logic i_reset;
  hazard_detection_if #(.REG_ADDR_SIZE(5)) hd_if ();

  hazard_detection #(.REG_ADDR_SIZE(5), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .hd      (hd_if)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: halting = waiting for the pipeline to empty, edges_left = edges still needed.
  bit          m_halting = 1'b0;
  bit          m_halted  = 1'b0;
  int          m_edges_left = 0;
  int unsigned m_stalls = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle against the queued expectation.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_write",     {15'd0, hd_if.o_pc_write},     {15'd0, e.pc_write});
      chk("if_id_write",  {15'd0, hd_if.o_if_id_write},  {15'd0, e.if_id_write});
      chk("if_id_flush",  {15'd0, hd_if.o_if_id_flush},  {15'd0, e.flush});
      chk("id_ex_bubble", {15'd0, hd_if.o_id_ex_bubble}, {15'd0, e.bubble});
      chk("halted",       {15'd0, hd_if.o_halted},       {15'd0, e.halted});
      chk("stall_count",  hd_if.o_stall_count,           e.stalls);
    end
  end

  // Apply one cycle of inputs just after a rising edge, queue the expectation, then advance the model.
  task automatic step(input bit en, input bit rstn, input logic [4:0] rs, input logic [4:0] rt,
                      input bit uses_rt, input bit mem_read, input logic [4:0] ex_rt,
                      input bit jump, input bit halt);
    exp_t e;
    bit   haz;
    i_reset               = rstn;
    hd_if.i_enable        = en;
    hd_if.i_id_rs         = rs;
    hd_if.i_id_rt         = rt;
    hd_if.i_id_uses_rt    = uses_rt;
    hd_if.i_ex_mem_read   = mem_read;
    hd_if.i_ex_rt         = ex_rt;
    hd_if.i_id_jump_taken = jump;
    hd_if.i_id_halt       = halt;
    if (!rstn) begin
      m_halting = 1'b0; m_halted = 1'b0; m_edges_left = 0; m_stalls = 0;
    end
    haz = mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    e = '{pc_write: 1'b0, if_id_write: 1'b0, flush: 1'b0, bubble: 1'b0,
          halted: m_halted, stalls: 16'(m_stalls)};
    if (rstn && en) begin
      if (m_halting || m_halted) e.bubble = 1'b1;
      else if (haz)              e.bubble = 1'b1;
      else if (!halt) begin
        e.pc_write = 1'b1; e.if_id_write = 1'b1; e.flush = jump;
      end
    end
    exp_q.push_back(e);
    @(posedge i_clk);
    if (rstn && en) begin
      if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_halting) begin
        m_edges_left--;
        if (m_edges_left == 0) begin m_halting = 1'b0; m_halted = 1'b1; end
      end else if (haz) begin
        if (m_stalls < 32'd65535) m_stalls++;
      end else if (halt) begin
        m_halting = 1'b1; m_edges_left = DRAIN;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0);
  endtask

  initial begin
    i_reset = 1'b0;
    hd_if.i_enable = 1'b0; hd_if.i_id_rs = '0; hd_if.i_id_rt = '0; hd_if.i_id_uses_rt = 1'b0;
    hd_if.i_ex_mem_read = 1'b0; hd_if.i_ex_rt = '0; hd_if.i_id_jump_taken = 1'b0; hd_if.i_id_halt = 1'b0;
    @(posedge i_clk); #1;
    // Reset state, including inputs that would otherwise stall or run.
    step(1, 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0);
    step(1, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
    idle(2);
    // Load-use on rs, then the hazard clears.
    step(1, 1, 5'd5, 5'd3, 0, 1, 5'd5, 0, 0);
    idle(1);
    // Load into $0 never stalls.
    step(1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0);
    // rt match only counts when rt is a source.
    step(1, 1, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0);
    step(1, 1, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0);
    // Plain taken jump flushes IF/ID.
    step(1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0);
    // Hazard beats halt and jump; next cycle halt beats jump.
    step(1, 1, 5'd5, 5'd3, 0, 1, 5'd5, 1, 1);
    step(1, 1, 5'd5, 5'd3, 0, 0, 5'd5, 1, 1);
    idle(DRAIN + 3);
    // Halt with a three-cycle freeze mid-drain; halt/jump ignored during drain.
    step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    idle(1);
    step(1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
    step(1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
    idle(DRAIN + 2);
    // Async reset mid-drain, asserted between edges.
    step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    idle(1);
    step(1, 1, 5'd4, 5'd2, 0, 1, 5'd4, 0, 0);
    step(1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
    idle(2);
    step(1, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
    idle(2);
    // Randomised traffic over a small register range so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 99) >= 3,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
    // Saturation: 65534 stalls bring the count to FFFE, three more must stop at FFFF.
    step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 65534; i++) step(1, 1, 5'd9, 5'd0, 0, 1, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++)     step(1, 1, 5'd9, 5'd0, 0, 1, 5'd9, 0, 0);
    idle(2);
    // Bounded wait for the monitor to drain the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge i_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
